// File: rtl/glenn_param_decoder_scan.sv
// glenn_param_decoder_scan: registered one-hot decoder with direct select and dwell-timed scan
module glenn_param_decoder_scan #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    dir,
  input  logic                    load,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   dout,
  output logic [SEL_W-1:0]        idx,
  output logic                    valid,
  output logic                    wrap
);
  localparam int N_OUT = 1 << SEL_W;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [N_OUT-1:0] ONE = 1;
  logic [CW-1:0] cnt;
  logic scan_act, step;
  logic [SEL_W-1:0] stepped, nidx;
  always_comb begin
    step = scan_act && !load && cnt == LAST;
    stepped = dir ? idx + 1'b1 : idx - 1'b1;
    nidx = (!mode || load) ? sel : step ? stepped : idx;
  end
  // scan_act only becomes set after one scan cycle, so entry holds the current index first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= '0;
      idx <= '0;
      valid <= 1'b0;
      wrap <= 1'b0;
      cnt <= '0;
      scan_act <= 1'b0;
    end else if (!en) begin
      dout <= '0;
      valid <= 1'b0;
      wrap <= 1'b0;
      cnt <= '0;
      scan_act <= 1'b0;
    end else begin
      idx <= nidx;
      dout <= ONE << nidx;
      valid <= 1'b1;
      wrap <= mode && step && (dir ? &idx : ~|idx);
      cnt <= (mode && scan_act && !load && !step) ? cnt + 1'b1 : '0;
      scan_act <= mode;
    end
endmodule
